// File: rtl/mem_ctrl.sv
// Memory-stage access controller: one cache handshake per EX/MEM access, dump on halt.
// Latency: IDLE+REQ+WAIT stall cycles, then a 1-cycle DONE; done-with-accept skips WAIT.
// Backpressure: mem_stall holds REQ and re-drives the strobe; stall freezes the pipeline.
// Optional: `define MEM_ALIGN_CHECK_EN to reject odd addresses (err, no strobe, no stall).
module mem_ctrl #(
  parameter int DW      = 16,
  parameter int AW      = 16,
  parameter int TIMEOUT = 64
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          DMemEn_tomem,
  input  logic          DMemWrite_tomem,
  input  logic          DMemDump_tomem,
  input  logic          Halt_tomem,
  input  logic [AW-1:0] ALUOut_tomem,
  input  logic [DW-1:0] ReadData2_tomem,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic          mem_rd,
  output logic          mem_wr,
  output logic          mem_createdump,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_done,
  input  logic          mem_stall,
  output logic          stall,
  output logic [DW-1:0] ld_data,
  output logic          ld_valid,
  output logic          halted,
  output logic          err
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] TMO = CW'(TIMEOUT);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    REQ    = 3'd1,
    WAIT   = 3'd2,
    DONE   = 3'd3,
    HALTED = 3'd4
  } state_t;

  state_t        state, stateNext;
  logic [CW-1:0] waitCnt;
  logic [CW-1:0] cntInc;
  logic          isWrite;     // access type latched on accept; EX/MEM is frozen anyway
  logic          ldCaptured;  // current access is a load whose data was captured
  logic          acceptReq;
  logic          captureNow;
  logic          timeoutNow;
  logic          alignErr;

  assign cntInc = waitCnt + CW'(1);

  // State register; reset drops any in-flight request.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= stateNext;
    end
  end

  // Next-state and strobe/stall decode.
  always_comb begin
    stateNext      = state;
    stall          = 1'b0;
    mem_rd         = 1'b0;
    mem_wr         = 1'b0;
    mem_createdump = 1'b0;
    acceptReq      = 1'b0;
    captureNow     = 1'b0;
    timeoutNow     = 1'b0;
    alignErr       = 1'b0;
    case (state)
      IDLE: begin
        if (DMemDump_tomem || Halt_tomem) begin
          // Dump wins over any access issued by the same instruction.
          mem_createdump = 1'b1;
          stateNext      = HALTED;
        end else if (DMemEn_tomem) begin
`ifdef MEM_ALIGN_CHECK_EN
          if (ALUOut_tomem[0]) begin
            // Misaligned access retires as a no-op with a sticky error.
            alignErr = 1'b1;
          end else begin
            acceptReq = 1'b1;
            stall     = 1'b1;
            stateNext = REQ;
          end
`else
          acceptReq = 1'b1;
          stall     = 1'b1;
          stateNext = REQ;
`endif
        end
      end
      REQ: begin
        stall  = 1'b1;
        mem_rd = ~isWrite;
        mem_wr = isWrite;
        if (!mem_stall) begin
          if (mem_done) begin
            captureNow = 1'b1;
            stateNext  = DONE;
          end else begin
            stateNext = WAIT;
          end
        end
      end
      WAIT: begin
        stall = 1'b1;
        if (mem_done) begin
          captureNow = 1'b1;
          stateNext  = DONE;
        end else if (cntInc == TMO) begin
          timeoutNow = 1'b1;
          stateNext  = DONE;
        end
      end
      DONE: begin
        stateNext = IDLE;
      end
      HALTED: begin
        stateNext = HALTED;
      end
      default: begin
        stateNext = IDLE;
      end
    endcase
  end

  // Address/data latch, wait counter, load capture and sticky error.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_addr   <= '0;
      mem_wdata  <= '0;
      isWrite    <= 1'b0;
      waitCnt    <= '0;
      ld_data    <= '0;
      ldCaptured <= 1'b0;
      err        <= 1'b0;
    end else begin
      if (acceptReq) begin
        mem_addr   <= ALUOut_tomem;
        mem_wdata  <= ReadData2_tomem;
        isWrite    <= DMemWrite_tomem;
        ldCaptured <= 1'b0;
      end
      if (acceptReq || state == REQ) begin
        waitCnt <= '0;
      end else if (state == WAIT) begin
        waitCnt <= cntInc;
      end
      if (captureNow && !isWrite) begin
        ld_data    <= mem_rdata;
        ldCaptured <= 1'b1;
      end
      if (timeoutNow || alignErr) begin
        err <= 1'b1;
      end
    end
  end

  assign ld_valid = (state == DONE) && ldCaptured;
  assign halted   = (state == HALTED);

endmodule

// File: tb/tb_mem_ctrl.sv
module tb_mem_ctrl;

  localparam int DW      = 16;
  localparam int AW      = 16;
  localparam int TIMEOUT = 64;

  logic          clk = 1'b0;
  logic          rst;
  logic          DMemEn_tomem, DMemWrite_tomem, DMemDump_tomem, Halt_tomem;
  logic [AW-1:0] ALUOut_tomem;
  logic [DW-1:0] ReadData2_tomem;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_rd, mem_wr, mem_createdump;
  logic [DW-1:0] mem_rdata;
  logic          mem_done, mem_stall;
  logic          stall;
  logic [DW-1:0] ld_data;
  logic          ld_valid, halted, err;

  int checks = 0;
  int errors = 0;

  // Reference state: last load value and sticky error, per the access rules.
  logic [DW-1:0] expLd;
  logic          expErr;

  mem_ctrl #(.DW(DW), .AW(AW), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .DMemEn_tomem(DMemEn_tomem), .DMemWrite_tomem(DMemWrite_tomem),
    .DMemDump_tomem(DMemDump_tomem), .Halt_tomem(Halt_tomem),
    .ALUOut_tomem(ALUOut_tomem), .ReadData2_tomem(ReadData2_tomem),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_createdump(mem_createdump),
    .mem_rdata(mem_rdata), .mem_done(mem_done), .mem_stall(mem_stall),
    .stall(stall), .ld_data(ld_data), .ld_valid(ld_valid),
    .halted(halted), .err(err)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog observed no finish expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One access against a scripted cache: busy for nBusy strobe cycles, done
  // doneLat cycles after acceptance (0 = with acceptance, -1 = never).
  task automatic doAccess(input bit wr, input logic [AW-1:0] addr, input logic [DW-1:0] data,
                          input int nBusy, input int doneLat, input logic [DW-1:0] rdata);
    int doneCycle, waitCyc, total;
    int stallCnt, rdCnt, wrCnt, vldCnt, addrBad;
    bit timedOut, expVld;
    logic [DW-1:0] ldBefore;
    timedOut  = (doneLat < 0);
    doneCycle = timedOut ? -1 : nBusy + 1 + doneLat;
    waitCyc   = timedOut ? TIMEOUT : doneLat;
    total     = 1 + (nBusy + 1) + waitCyc;   // stall cycles; DONE is cycle 'total'
    expVld    = !wr && !timedOut;
    stallCnt = 0; rdCnt = 0; wrCnt = 0; vldCnt = 0; addrBad = 0;
    for (int k = 0; k <= total; k++) begin
      @(negedge clk);
      DMemEn_tomem    = 1'b1;
      DMemWrite_tomem = wr;
      ALUOut_tomem    = addr;
      ReadData2_tomem = data;
      mem_stall       = (k >= 1 && k <= nBusy);
      mem_done        = (k == doneCycle);
      mem_rdata       = (k == doneCycle) ? rdata : DW'($urandom);
      #1;
      stallCnt += int'(stall);
      rdCnt    += int'(mem_rd);
      wrCnt    += int'(mem_wr);
      vldCnt   += int'(ld_valid);
      if ((mem_rd || mem_wr) && (mem_addr !== addr || (wr && mem_wdata !== data))) addrBad++;
      if (k == total) begin
        check("done_stall", {31'b0, stall}, 32'd0);
        check("done_ld_valid", {31'b0, ld_valid}, {31'b0, expVld});
      end
    end
    if (expVld) expLd = rdata;
    if (timedOut) expErr = 1'b1;
    // Idle cycle with a stray mem_done that must be ignored.
    @(negedge clk);
    DMemEn_tomem = 1'b0;
    mem_stall    = 1'b0;
    mem_done     = 1'($urandom_range(0, 1));
    mem_rdata    = DW'($urandom);
    #1;
    check("idle_stall", {31'b0, stall}, 32'd0);
    check("idle_ld_valid", {31'b0, ld_valid}, 32'd0);
    check("stall_cycles", stallCnt, total);
    check("rd_cycles", rdCnt, wr ? 0 : nBusy + 1);
    check("wr_cycles", wrCnt, wr ? nBusy + 1 : 0);
    check("ld_valid_cycles", vldCnt, {31'b0, expVld});
    check("addr_wdata_stable", addrBad, 0);
    check("ld_data", {16'b0, ld_data}, {16'b0, expLd});
    check("err", {31'b0, err}, {31'b0, expErr});
    ldBefore = ld_data;
    @(negedge clk);
    mem_done = 1'b0;
    #1;
    check("ld_data_hold", {16'b0, ld_data}, {16'b0, ldBefore});
  endtask

  initial begin
    int cnt;
    rst = 1'b1;
    DMemEn_tomem = 0; DMemWrite_tomem = 0; DMemDump_tomem = 0; Halt_tomem = 0;
    ALUOut_tomem = '0; ReadData2_tomem = '0;
    mem_rdata = '0; mem_done = 0; mem_stall = 0;
    expLd = '0; expErr = 1'b0;
    #1;
    check("rst_stall", {31'b0, stall}, 32'd0);
    check("rst_rd_wr", {30'b0, mem_rd, mem_wr}, 32'd0);
    check("rst_dump", {31'b0, mem_createdump}, 32'd0);
    check("rst_flags", {29'b0, ld_valid, halted, err}, 32'd0);
    check("rst_addr", {16'b0, mem_addr}, 32'd0);
    check("rst_ld_data", {16'b0, ld_data}, 32'd0);
    #20;
    @(negedge clk);
    rst = 1'b0;

    // Load at 0x0010, done two cycles after the strobe.
    doAccess(1'b0, 16'h0010, 16'h0000, 0, 2, 16'hBEEF);
    // Store at 0x0020 with three busy cycles, done on acceptance.
    doAccess(1'b1, 16'h0020, 16'h1234, 3, 0, 16'h0000);
    // Zero-wait and done-with-accept loads.
    doAccess(1'b0, 16'h0040, 16'h0000, 0, 1, 16'hA5A5);
    doAccess(1'b0, 16'h0042, 16'h0000, 0, 0, 16'h5A5A);

    // Randomized accesses.
    for (int i = 0; i < 40; i++) begin
      doAccess(1'($urandom_range(0, 1)), AW'($urandom) & ~AW'(1), DW'($urandom),
               $urandom_range(0, 3), $urandom_range(0, 4), DW'($urandom));
    end

    // Cache never completes: timeout after TIMEOUT wait cycles.
    doAccess(1'b0, 16'h0080, 16'h0000, 1, -1, 16'h0000);

    // Reset in the middle of WAIT.
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      DMemEn_tomem = 1'b1; DMemWrite_tomem = 1'b0; ALUOut_tomem = 16'h0100;
      mem_stall = 1'b0; mem_done = 1'b0;
    end
    @(negedge clk);
    rst = 1'b1;
    DMemEn_tomem = 1'b0;
    #1;
    expLd = '0; expErr = 1'b0;
    check("midrst_stall", {31'b0, stall}, 32'd0);
    check("midrst_rd", {31'b0, mem_rd}, 32'd0);
    check("midrst_addr", {16'b0, mem_addr}, 32'd0);
    check("midrst_err", {31'b0, err}, 32'd0);
    check("midrst_ld_data", {16'b0, ld_data}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    doAccess(1'b0, 16'h0102, 16'h0000, 1, 2, 16'hC0DE);

    // Misaligned load.
`ifdef MEM_ALIGN_CHECK_EN
    cnt = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      DMemEn_tomem = 1'b1; DMemWrite_tomem = 1'b0; ALUOut_tomem = 16'h0011;
      #1;
      cnt += int'(stall) + int'(mem_rd) + int'(mem_wr);
    end
    @(negedge clk);
    DMemEn_tomem = 1'b0;
    #1;
    expErr = 1'b1;
    check("align_no_activity", cnt, 0);
    check("align_err", {31'b0, err}, {31'b0, expErr});
`else
    doAccess(1'b0, 16'h0011, 16'h0000, 0, 1, 16'h1111);
`endif

    // Halt together with an access request.
    @(negedge clk);
    Halt_tomem = 1'b1; DMemEn_tomem = 1'b1; DMemWrite_tomem = 1'b0; ALUOut_tomem = 16'h0200;
    #1;
    check("halt_dump", {31'b0, mem_createdump}, 32'd1);
    check("halt_no_strobe", {30'b0, mem_rd, mem_wr}, 32'd0);
    check("halt_not_yet", {31'b0, halted}, 32'd0);
    @(negedge clk);
    Halt_tomem = 1'b0;
    #1;
    check("halted", {31'b0, halted}, 32'd1);
    cnt = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      DMemEn_tomem = 1'b1; DMemWrite_tomem = 1'($urandom_range(0, 1));
      DMemDump_tomem = 1'($urandom_range(0, 1));
      mem_done = 1'($urandom_range(0, 1));
      #1;
      cnt += int'(stall) + int'(mem_rd) + int'(mem_wr) + int'(mem_createdump) + int'(ld_valid);
    end
    check("halted_inert", cnt, 0);
    check("halted_sticky", {31'b0, halted}, 32'd1);
    check("halted_ld_data", {16'b0, ld_data}, {16'b0, expLd});

    @(negedge clk);
    DMemEn_tomem = 1'b0; DMemDump_tomem = 1'b0; mem_done = 1'b0;
    rst = 1'b1;
    #1;
    check("post_halt_rst", {31'b0, halted}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
